// File: rtl/m68k_bus_responder.sv
// m68k_bus_responder: oversampled MC68000 bus target serving a 16-bit register file with fixed wait states
module m68k_bus_responder #(
  parameter logic [23:0] BASE_ADDR   = 24'hE80000,
  parameter int          ADDR_BITS   = 4,
  parameter int          WAIT_CYCLES = 4
) (
  input  logic                 PI_CLK,
  input  logic                 RESET,
  input  logic                 M68K_AS_n,
  input  logic                 M68K_UDS_n,
  input  logic                 M68K_LDS_n,
  input  logic                 M68K_RW,
  input  logic [23:1]          M68K_A,
  input  logic [15:0]          M68K_D_IN,
  output logic [15:0]          M68K_D_OUT,
  output logic                 M68K_D_OE,
  output logic                 M68K_DTACK_n,
  output logic                 M68K_DTACK_OE,
  input  logic [ADDR_BITS-1:0] HOST_ADDR,
  input  logic                 HOST_WE,
  input  logic [15:0]          HOST_WDATA,
  output logic [15:0]          HOST_RDATA,
  output logic                 BUS_WR_PULSE,
  output logic [ADDR_BITS-1:0] BUS_WR_ADDR
);
  localparam int DEPTH = 1 << ADDR_BITS;
  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_WAIT, S_ACK, S_RELEASE, S_MISS} state_t;
  state_t r_state;
  logic [3:0] r_sync1, r_sync2;
  logic [15:0] r_regs [DEPTH];
  logic [ADDR_BITS-1:0] r_idx;
  logic r_ue, r_le, r_rw, r_armed;
  logic [15:0] r_din;
  logic [3:0] r_cnt;
  logic [1:0] r_vld;
  logic w_as, w_qual, w_hit, w_to_ack, w_commit;
  logic [15:0] w_host, w_merged;
  assign w_as = r_sync2[3];
  assign w_qual = !w_as && (!r_sync2[2] || !r_sync2[1]);
  assign w_hit = M68K_A[23:ADDR_BITS+1] == BASE_ADDR[23:ADDR_BITS+1];
  assign w_to_ack = !w_as && ((r_state == S_DECODE && WAIT_CYCLES == 0) || (r_state == S_WAIT && r_cnt == 4'd1));
  assign w_commit = w_to_ack && !r_rw;
  // A same-edge host write to the target word supplies the lanes the bus leaves untouched
  assign w_host = (HOST_WE && HOST_ADDR == r_idx) ? HOST_WDATA : r_regs[r_idx];
  assign w_merged = {r_ue ? r_din[15:8] : w_host[15:8], r_le ? r_din[7:0] : w_host[7:0]};
  always_ff @(posedge PI_CLK) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
      HOST_RDATA <= '0;
    end else begin
      HOST_RDATA <= r_regs[HOST_ADDR];
      if (HOST_WE) r_regs[HOST_ADDR] <= HOST_WDATA;
      if (w_commit) r_regs[r_idx] <= w_merged;
    end
  end
  always_ff @(posedge PI_CLK) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_sync1 <= '1;
      r_sync2 <= '1;
      r_vld <= '0;
      r_armed <= 1'b0;
      r_idx <= '0;
      r_ue <= 1'b0;
      r_le <= 1'b0;
      r_rw <= 1'b1;
      r_din <= '0;
      r_cnt <= '0;
      M68K_DTACK_n <= 1'b1;
      M68K_DTACK_OE <= 1'b0;
      M68K_D_OE <= 1'b0;
      M68K_D_OUT <= '0;
      BUS_WR_PULSE <= 1'b0;
      BUS_WR_ADDR <= '0;
    end else begin
      r_sync1 <= {M68K_AS_n, M68K_UDS_n, M68K_LDS_n, M68K_RW};
      r_sync2 <= r_sync1;
      r_vld <= {r_vld[0], 1'b1};
      BUS_WR_PULSE <= w_commit;
      if (w_commit) BUS_WR_ADDR <= r_idx;
      // Only accept a cycle after AS has been seen high through a fully refilled synchroniser
      if (r_vld[1] && w_as) r_armed <= 1'b1;
      case (r_state)
        S_IDLE: if (r_armed && w_qual) begin
          r_armed <= 1'b0;
          r_state <= w_hit ? S_DECODE : S_MISS;
          r_idx <= M68K_A[ADDR_BITS:1];
          r_ue <= !r_sync2[2];
          r_le <= !r_sync2[1];
          r_rw <= r_sync2[0];
          r_din <= M68K_D_IN;
        end
        S_DECODE: if (w_as) begin
          r_state <= S_RELEASE;
          M68K_DTACK_OE <= 1'b1;
        end else begin
          r_state <= w_to_ack ? S_ACK : S_WAIT;
          r_cnt <= 4'(WAIT_CYCLES);
          M68K_DTACK_n <= !w_to_ack;
          M68K_DTACK_OE <= w_to_ack;
          M68K_D_OE <= r_rw;
          if (r_rw) M68K_D_OUT <= r_regs[r_idx];
        end
        S_WAIT: if (w_as) begin
          r_state <= S_RELEASE;
          M68K_DTACK_OE <= 1'b1;
          M68K_D_OE <= 1'b0;
        end else if (w_to_ack) begin
          r_state <= S_ACK;
          M68K_DTACK_n <= 1'b0;
          M68K_DTACK_OE <= 1'b1;
        end else r_cnt <= r_cnt - 4'd1;
        S_ACK: if (w_as) begin
          r_state <= S_RELEASE;
          M68K_DTACK_n <= 1'b1;
          M68K_D_OE <= 1'b0;
        end
        S_RELEASE: begin
          r_state <= S_IDLE;
          M68K_DTACK_OE <= 1'b0;
        end
        S_MISS: if (w_as) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
